// File: rtl/led_step_ctrl_pkg.sv
// led_step_ctrl_pkg: shared state encoding and default parameters for the LED step controller.
package led_step_ctrl_pkg;
   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2
   } step_state_t;
   localparam int DIV_DEFAULT        = 4194304;
   localparam int DEB_CYCLES_DEFAULT = 65536;
   localparam int COUNT_W_DEFAULT    = 5;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, optional debouncer and rising-edge press pulse.
// Debouncer present only when LED_STEP_CTRL_DEBOUNCE_EN is defined.
module btn_debounce
   import led_step_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       deb;
`ifdef LED_STEP_CTRL_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d;
   logic          done;
   always_comb begin
      done  = cnt_q == CW'(DEB_CYCLES - 1);
      deb_d = (sync_q[1] != deb_q && done) ? sync_q[1] : deb_q;
      cnt_d = (sync_q[1] == deb_q || done) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end
   assign deb = deb_q;
`else
   logic unused_deb;
   assign unused_deb = ^DEB_CYCLES;
   assign deb = sync_q[1];
`endif
   always_comb begin
      sync_d = {sync_q[0], btn};
      prev_d = deb;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end
   assign press = deb & ~prev_q;
endmodule

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: run/pause/single-step sequencer driving a clock-enabled LED counter.
// Debouncing of both buttons is enabled by defining LED_STEP_CTRL_DEBOUNCE_EN.
module led_step_ctrl
   import led_step_ctrl_pkg::*;
#(
   parameter int DIV        = DIV_DEFAULT,
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int COUNT_W    = COUNT_W_DEFAULT
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               BTN_RUN,
   input  logic               BTN_STEP,
   output logic               TICK,
   output logic [COUNT_W-1:0] COUNT,
   output logic               RUNNING
);
   localparam int PW = $clog2(DIV);
   step_state_t        state_q, state_d;
   logic [PW-1:0]      pre_q, pre_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               run_press, step_press, wrap;
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
      .clk(CLK), .rst(RST), .btn(BTN_RUN), .press(run_press)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
      .clk(CLK), .rst(RST), .btn(BTN_STEP), .press(step_press)
   );
   // Run beats step when both presses land together; STEP always lasts one cycle.
   always_comb begin
      wrap    = pre_q == PW'(DIV - 1);
      state_d = (state_q == PAUSED) ? (run_press ? RUN : step_press ? STEP : PAUSED) :
                (state_q == RUN)    ? (run_press ? PAUSED : RUN) : PAUSED;
      pre_d   = (state_q == PAUSED && run_press) ? '0 :
                (state_q == RUN) ? (wrap ? '0 : pre_q + 1'b1) : pre_q;
      TICK    = (state_q == STEP) || (state_q == RUN && wrap);
      count_d = count_q + COUNT_W'(TICK);
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= PAUSED;
         pre_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         count_q <= count_d;
      end
   end
   assign COUNT   = count_q;
   assign RUNNING = state_q == RUN;
endmodule

// File: tb/tb_led_step_ctrl.sv
// tb_led_step_ctrl: directed checks of reset, step, run cadence/wrap, bounce rejection and reset mid-run.
module tb_led_step_ctrl;
   localparam int DIV = 4;
   localparam int DEB = 3;
`ifdef LED_STEP_CTRL_DEBOUNCE_EN
   localparam int LAT = DEB;
`else
   localparam int LAT = 0;
`endif
   logic       CLK = 1'b0, RST = 1'b1, BTN_RUN = 1'b0, BTN_STEP = 1'b0;
   logic       TICK, RUNNING;
   logic [4:0] COUNT;
   int         checks = 0, errors = 0, t;
   led_step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .COUNT_W(5)) dut (
      .CLK(CLK), .RST(RST), .BTN_RUN(BTN_RUN), .BTN_STEP(BTN_STEP),
      .TICK(TICK), .COUNT(COUNT), .RUNNING(RUNNING)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic adv();
      @(negedge CLK);
   endtask
   task automatic adv_n(input int n, output int ticks);
      ticks = 0;
      repeat (n) begin
         @(negedge CLK);
         ticks += int'(TICK);
      end
   endtask
   initial begin
      // reset held two cycles with buttons toggling
      for (int i = 0; i < 2; i++) begin
         adv();
         check("rst_count", COUNT, 0);
         check("rst_tick", TICK, 0);
         check("rst_running", RUNNING, 0);
         BTN_RUN  = ~BTN_RUN;
         BTN_STEP = BTN_RUN;
      end
      RST = 1'b0; BTN_RUN = 1'b0; BTN_STEP = 1'b0;
      adv();
      check("post_rst_count", COUNT, 0);
      check("post_rst_tick", TICK, 0);
      check("post_rst_running", RUNNING, 0);
      adv_n(5, t);
      check("idle_ticks", t, 0);
      // single step
      BTN_STEP = 1'b1;
      adv_n(2 + LAT, t);
      check("step_early_ticks", t, 0);
      adv();
      check("step_tick", TICK, 1);
      check("step_count_before", COUNT, 0);
      adv();
      check("step_count_after", COUNT, 1);
      check("step_tick_gone", TICK, 0);
      adv_n(14, t);
      check("step_hold_ticks", t, 0);
      BTN_STEP = 1'b0;
      adv_n(10, t);
      check("step_release_ticks", t, 0);
      check("step_count_hold", COUNT, 1);
      // run: RUNNING from R, ticks at R+3, R+7, ...
      BTN_RUN = 1'b1;
      adv_n(2 + LAT, t);
      check("run_not_yet", RUNNING, 0);
      adv();
      check("run_entered", RUNNING, 1);
      check("run_no_tick_at_entry", TICK, 0);
      adv_n(3, t);
      check("run_first_tick", TICK, 1);
      check("run_first_tick_count", t, 1);
      check("run_count_r3", COUNT, 1);
      adv();
      check("run_count_r4", COUNT, 2);
      BTN_RUN = 1'b0;
      adv_n(116, t);
      check("run_ticks_116", t, 29);
      check("run_count_31", COUNT, 31);
      adv_n(3, t);
      check("run_tick_r123", TICK, 1);
      adv();
      check("run_wrap", COUNT, 0);
      adv_n(6 - LAT, t);
      BTN_RUN = 1'b1;
      adv_n(3 + LAT, t);
      check("pause_running", RUNNING, 0);
      check("pause_count", COUNT, 2);
      BTN_RUN = 1'b0;
      adv_n(15, t);
      check("pause_ticks", t, 0);
      check("pause_count_hold", COUNT, 2);
`ifdef LED_STEP_CTRL_DEBOUNCE_EN
      // bounce: 1-2 cycle pulses separated by 1-cycle gaps
      for (int i = 0; i < 20; i++) begin
         BTN_STEP = (i % 5) != 1 && (i % 5) != 4;
         adv();
      end
      BTN_STEP = 1'b0;
      adv_n(10, t);
      check("bounce_ticks", t, 0);
      check("bounce_count", COUNT, 2);
`endif
      // simultaneous presses: run wins, no step tick
      BTN_RUN = 1'b1; BTN_STEP = 1'b1;
      adv_n(3 + LAT, t);
      check("simul_running", RUNNING, 1);
      check("simul_ticks", t, 0);
      check("simul_count", COUNT, 2);
      BTN_RUN = 1'b0; BTN_STEP = 1'b0;
      adv_n(3, t);
      check("simul_tick_r3", TICK, 1);
      adv_n(4, t);
      check("simul_tick_r7", TICK, 1);
      BTN_STEP = 1'b1;
      adv_n(16, t);
      check("run_step_ignored_ticks", t, 4);
      check("run_step_tick_r23", TICK, 1);
      check("run_step_running", RUNNING, 1);
      check("run_step_count", COUNT, 7);
      // reset on the pre==DIV-1 cycle
      RST = 1'b1; BTN_STEP = 1'b0;
      adv();
      check("midrst_count", COUNT, 0);
      check("midrst_running", RUNNING, 0);
      check("midrst_tick", TICK, 0);
      RST = 1'b0;
      adv_n(6, t);
      check("midrst_idle_ticks", t, 0);
      check("midrst_idle_count", COUNT, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
